// File: rtl/fp16_pkg.sv
// FP16 (1-5-10) shared definitions for the fixed-point to FP16 encoder.
//   fp16_t      : packed FP16 word {sign, exp, man}
//   enc_state_e : encoder control states
package fp16_pkg;

  localparam int unsigned FP16_EXP_BITS = 5;
  localparam int unsigned FP16_MAN_BITS = 10;
  localparam int unsigned FP16_BIAS     = 15;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;

  // Width of the signed running exponent; wide enough for any sane ACC_WIDTH/FRAC_BITS mix.
  localparam int unsigned EXP_CNT_W = 8;

  typedef struct packed {
    logic                     sign;
    logic [FP16_EXP_BITS-1:0] exp;
    logic [FP16_MAN_BITS-1:0] man;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } enc_state_e;

endpackage

// File: rtl/fp16_rne_pack.sv
// Combinational FP16 packer: takes a sign, a magnitude that is either normalised (MSB set) or
// a subnormal (MSB clear, exponent at its floor of 1) and the biased exponent, and produces the
// round-to-nearest-even FP16 word, saturating to signed infinity on overflow.
//   sign_i    : result sign
//   mag_i     : magnitude, binary point just below the MSB
//   exp_cnt_i : biased exponent (>= 1)
//   result_o  : packed FP16 result
module fp16_rne_pack
  import fp16_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                        sign_i,
  input  logic [ACC_WIDTH-1:0]        mag_i,
  input  logic signed [EXP_CNT_W-1:0] exp_cnt_i,
  output fp16_t                       result_o
);

  localparam int unsigned GuardIdx = ACC_WIDTH - 2 - FP16_MAN_BITS;
  localparam logic signed [EXP_CNT_W-1:0] ExpInf = EXP_CNT_W'(31);

  logic [FP16_MAN_BITS-1:0] man;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic                     is_normal;
  logic                     overflow;
  logic [14:0]              field;
  logic [14:0]              packed_sum;

  always_comb begin
    is_normal = mag_i[ACC_WIDTH-1];
    man       = mag_i[ACC_WIDTH-2 -: FP16_MAN_BITS];
    guard     = mag_i[GuardIdx];
    sticky    = |mag_i[GuardIdx-1:0];
    round_up  = guard & (sticky | man[0]);
    // Subnormals encode with a zero exponent field; a round-up carry out of the mantissa
    // lands in the exponent, which is exactly the right next representable value.
    field      = {(is_normal ? exp_cnt_i[4:0] : 5'd0), man};
    packed_sum = field + 15'(round_up);
    overflow   = (exp_cnt_i >= ExpInf) || (packed_sum[14:10] == 5'h1F);

    result_o.sign = sign_i;
    if (overflow) begin
      {result_o.exp, result_o.man} = FP16_POS_INF[14:0];
    end else begin
      {result_o.exp, result_o.man} = packed_sum;
    end
  end

endmodule

// File: rtl/fixed_to_fp16_enc.sv
// Iterative signed fixed-point to FP16 encoder (RNE, subnormals kept).
// Accepts one word when idle, normalises it one left shift per cycle, rounds and packs, then
// holds the result until the consumer takes it.
//   clk_i / rst_i           : clock, synchronous active-high reset
//   in_valid_i / in_ready_o : input handshake; ready only when idle
//   in_data_i               : two's complement word, value = in_data_i / 2**FRAC_BITS
//   out_valid_o/out_ready_i : output handshake; result held until taken
//   out_data_o              : FP16 result {sign, exp, man}
module fixed_to_fp16_enc
  import fp16_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 20,
  parameter int unsigned BIAS      = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ACC_WIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          out_data_o
);

  // Biased exponent of a value whose leading one sits in the input MSB.
  localparam int E0 = int'(ACC_WIDTH) - 1 - int'(FRAC_BITS) + int'(BIAS);
  localparam logic signed [EXP_CNT_W-1:0] ExpOne = EXP_CNT_W'(1);

  if (E0 < 1) begin : gen_bad_e0
    $error("fixed_to_fp16_enc: ACC_WIDTH-1-FRAC_BITS+BIAS must be >= 1");
  end
  if (E0 >= (1 << (EXP_CNT_W - 1))) begin : gen_bad_e0_width
    $error("fixed_to_fp16_enc: starting exponent does not fit the exponent counter");
  end
  if (ACC_WIDTH < 13) begin : gen_bad_width
    $error("fixed_to_fp16_enc: ACC_WIDTH must leave room for mantissa, guard and sticky");
  end

  enc_state_e                  state_q, state_d;
  logic                        sign_q, sign_d;
  logic [ACC_WIDTH-1:0]        mag_q, mag_d;
  logic signed [EXP_CNT_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [15:0]                 out_data_q, out_data_d;
  fp16_t                       packed_res;

  fp16_rne_pack #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_pack (
    .sign_i    (sign_q),
    .mag_i     (mag_q),
    .exp_cnt_i (exp_cnt_q),
    .result_o  (packed_res)
  );

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_cnt_d  = exp_cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sign_d    = in_data_i[ACC_WIDTH-1];
          // Most-negative input negates to 2**(ACC_WIDTH-1), still correct as unsigned.
          mag_d     = in_data_i[ACC_WIDTH-1] ? (~in_data_i + ACC_WIDTH'(1)) : in_data_i;
          exp_cnt_d = EXP_CNT_W'(E0);
          if (in_data_i == '0) begin
            out_data_d = 16'h0000;
            state_d    = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        // Exponent floor of 1 stops the shift: whatever is left is a subnormal.
        if (mag_q[ACC_WIDTH-1] || (exp_cnt_q == ExpOne)) begin
          state_d = ROUND;
        end else begin
          mag_d     = mag_q << 1;
          exp_cnt_d = exp_cnt_q - ExpOne;
        end
      end
      ROUND: begin
        out_data_d = packed_res;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_cnt_q  <= '0;
      out_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_cnt_q  <= exp_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = out_data_q;

endmodule
